button_debouncer: RTL and testbench

- Input-side counterpart to the LED blink driver: conditions a raw, bouncing push-button (or switch) input into a clean, clock-synchronous level plus single-cycle press/release events.
- Maintains a wrapping press counter for board-level bring-up and LED display.
- Sits between the board pin and any control logic in the Clock_IN domain.

---
 rtl/button_debouncer.sv | 125 ++++++++++++
 tb/tb_button_debouncer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
// Push-button conditioner: 2-FF synchronizer, stability-qualified level,
// single-cycle press/release events and a wrapping press counter.
module button_debouncer #(
  parameter int STABLE_CYCLES = 1000000,
  parameter int CNT_WIDTH     = 20
) (
  input  logic       Clock_IN,
  input  logic       Reset,
  input  logic       Button_IN,
  output logic       Button_Level,
  output logic       Press_Pulse,
  output logic       Release_Pulse,
  output logic [7:0] Press_Count
);

  localparam logic [1:0] IDLE_LOW  = 2'd0;
  localparam logic [1:0] WAIT_HIGH = 2'd1;
  localparam logic [1:0] IDLE_HIGH = 2'd2;
  localparam logic [1:0] WAIT_LOW  = 2'd3;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST =
    CNT_WIDTH'(STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE =
    CNT_WIDTH'(1);

  logic                 sync_q1;
  logic                 sync_q2;
  logic [1:0]           state;
  logic [1:0]           state_nxt;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_nxt;
  logic                 level_nxt;
  logic                 press_nxt;
  logic                 release_nxt;
  logic [7:0]           count_nxt;

  always_ff @(posedge Clock_IN or posedge Reset) begin
    if (Reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= Button_IN;
      sync_q2 <= sync_q1;
    end
  end

  // The entering sample counts as the first of the qualifying run.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    level_nxt   = Button_Level;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    count_nxt   = Press_Count;
    case (state)
      IDLE_LOW: begin
        if (sync_q2) begin
          state_nxt = WAIT_HIGH;
          cnt_nxt   = CNT_ONE;
        end else begin
          cnt_nxt = '0;
        end
      end
      WAIT_HIGH: begin
        if (!sync_q2) begin
          state_nxt = IDLE_LOW;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE_HIGH;
          cnt_nxt   = '0;
          level_nxt = 1'b1;
          press_nxt = 1'b1;
          count_nxt = Press_Count + 8'd1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      IDLE_HIGH: begin
        if (!sync_q2) begin
          state_nxt = WAIT_LOW;
          cnt_nxt   = CNT_ONE;
        end else begin
          cnt_nxt = '0;
        end
      end
      WAIT_LOW: begin
        if (sync_q2) begin
          state_nxt = IDLE_HIGH;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt   = IDLE_LOW;
          cnt_nxt     = '0;
          level_nxt   = 1'b0;
          release_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = IDLE_LOW;
        cnt_nxt   = '0;
        level_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clock_IN or posedge Reset) begin
    if (Reset) begin
      state         <= IDLE_LOW;
      cnt           <= '0;
      Button_Level  <= 1'b0;
      Press_Pulse   <= 1'b0;
      Release_Pulse <= 1'b0;
      Press_Count   <= 8'd0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      Button_Level  <= level_nxt;
      Press_Pulse   <= press_nxt;
      Release_Pulse <= release_nxt;
      Press_Count   <= count_nxt;
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Randomized and directed bench for button_debouncer against a
// run-length reference model of the debounce rule.
module tb_button_debouncer;

  localparam int STABLE = 4;

  logic       Clock_IN = 1'b0;
  logic       Reset = 1'b1;
  logic       Button_IN = 1'b0;
  logic       Button_Level;
  logic       Press_Pulse;
  logic       Release_Pulse;
  logic [7:0] Press_Count;

  button_debouncer #(
    .STABLE_CYCLES(STABLE),
    .CNT_WIDTH(3)
  ) dut (
    .Clock_IN(Clock_IN),
    .Reset(Reset),
    .Button_IN(Button_IN),
    .Button_Level(Button_Level),
    .Press_Pulse(Press_Pulse),
    .Release_Pulse(Release_Pulse),
    .Press_Count(Press_Count)
  );

  always #5 Clock_IN = ~Clock_IN;

  int n_checks = 0;
  int n_fail = 0;
  int n_press = 0;
  int n_rel = 0;

  bit m_f1, m_s, m_level, m_press, m_rel;
  int m_run, m_count;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_f1 = 0; m_s = 0; m_level = 0;
    m_press = 0; m_rel = 0;
    m_run = 0; m_count = 0;
  endfunction

  // Accept a new level once it has been seen for STABLE samples in a row.
  function automatic void model_step(input bit b);
    m_press = 0;
    m_rel = 0;
    if (m_s != m_level) begin
      m_run++;
      if (m_run == STABLE) begin
        m_level = m_s;
        m_run = 0;
        if (m_s) begin
          m_press = 1;
          m_count = (m_count + 1) % 256;
        end else begin
          m_rel = 1;
        end
      end
    end else begin
      m_run = 0;
    end
    m_s = m_f1;
    m_f1 = b;
  endfunction

  task automatic tick(input bit b, input bit r);
    @(negedge Clock_IN);
    Button_IN = b;
    Reset = r;
    @(posedge Clock_IN);
    if (r) model_reset();
    else model_step(b);
    #1;
    check("level", 32'(Button_Level), 32'(m_level));
    check("press", 32'(Press_Pulse), 32'(m_press));
    check("release", 32'(Release_Pulse), 32'(m_rel));
    check("count", 32'(Press_Count), 32'(m_count));
    if (Press_Pulse) n_press++;
    if (Release_Pulse) n_rel++;
  endtask

  task automatic hold(input bit b, input int n,
                      input int pat, input int rat);
    for (int i = 0; i < n; i++) begin
      tick(b, 1'b0);
      check("press_at", 32'(Press_Pulse), 32'(i == pat));
      check("release_at", 32'(Release_Pulse), 32'(i == rat));
    end
  endtask

  initial begin
    model_reset();
    repeat (5) tick(1'b0, 1'b1);
    check("rst_level", 32'(Button_Level), 32'd0);
    check("rst_press", 32'(Press_Pulse), 32'd0);
    check("rst_release", 32'(Release_Pulse), 32'd0);
    check("rst_count", 32'(Press_Count), 32'd0);

    hold(1'b1, 3, -1, -1);
    hold(1'b0, 1, -1, -1);
    hold(1'b1, 3, -1, -1);
    hold(1'b0, 10, -1, -1);
    check("bounce_level", 32'(Button_Level), 32'd0);
    check("bounce_count", 32'(Press_Count), 32'd0);

    hold(1'b1, 12, 5, -1);
    check("press_level", 32'(Button_Level), 32'd1);
    check("press_count", 32'(Press_Count), 32'd1);

    hold(1'b0, 10, -1, 5);
    check("rel_level", 32'(Button_Level), 32'd0);
    check("rel_count", 32'(Press_Count), 32'd1);

    for (int k = 0; k < 80; k++) begin
      bit v;
      int len;
      v = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 7));
      repeat (len) tick(v, 1'b0);
    end

    repeat (10) tick(1'b0, 1'b0);
    repeat (4) tick(1'b1, 1'b0);
    #2;
    Reset = 1'b1;
    model_reset();
    #1;
    check("arst_level", 32'(Button_Level), 32'd0);
    check("arst_press", 32'(Press_Pulse), 32'd0);
    check("arst_release", 32'(Release_Pulse), 32'd0);
    check("arst_count", 32'(Press_Count), 32'd0);
    repeat (2) tick(1'b1, 1'b1);
    hold(1'b1, 10, 5, -1);
    check("arst_press_count", 32'(Press_Count), 32'd1);

    repeat (2) tick(1'b0, 1'b1);
    hold(1'b0, 3, -1, -1);
    n_press = 0;
    n_rel = 0;
    for (int k = 1; k <= 256; k++) begin
      hold(1'b1, 7, 5, -1);
      if (k == 255) check("wrap_255", 32'(Press_Count), 32'd255);
      if (k == 256) check("wrap_0", 32'(Press_Count), 32'd0);
      hold(1'b0, 7, -1, 5);
    end
    check("n_press", 32'(n_press), 32'd256);
    check("n_release", 32'(n_rel), 32'd256);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
